// File: rtl/alu_mp_sequencer.sv
// alu_mp_sequencer: runs one multi-word ALU operation through an external n-bit ALU, one word per cycle
// Ports: cmd_* command handshake and operands in; alu_* drive the external combinational ALU
// and take its result back in the same cycle; rsp_* hold the assembled result until accepted.
// Optional: define ALU_SEQ_ZERO_FLAG_EN to add rsp_zero (high with rsp_valid when rsp_result==0).
module alu_mp_sequencer #(
  parameter int n     = 4,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_mode,
  input  logic [n*WORDS-1:0] cmd_a,
  input  logic [n*WORDS-1:0] cmd_b,
  input  logic               cmd_cb_in,
  output logic [n-1:0]       alu_a,
  output logic [n-1:0]       alu_b,
  output logic [2:0]         alu_mode,
  output logic               alu_cb_in,
  input  logic [n-1:0]       alu_result,
  input  logic               alu_cb_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [n*WORDS-1:0] rsp_result,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic               rsp_cb_out,
  output logic               rsp_zero
);
`else
  output logic               rsp_cb_out
);
`endif
  localparam int W  = n*WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS-1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0]  a_q, b_q, result_q;
  logic [2:0]    mode_q;
  logic          cbin_q, carry_q;
  logic [IW-1:0] idx_q;
  logic          run, first, arith, incdec;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cmd_valid ? RUN : IDLE;
      RUN:     state_d = (idx_q == LAST) ? DONE : RUN;
      DONE:    state_d = rsp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      mode_q   <= '0;
      cbin_q   <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
    end else if (state_q == IDLE && cmd_valid) begin
      a_q    <= cmd_a;
      b_q    <= cmd_b;
      mode_q <= cmd_mode;
      cbin_q <= cmd_cb_in;
      idx_q  <= '0;
    end else if (state_q == RUN) begin
      result_q[idx_q*n +: n] <= alu_result;
      carry_q                <= alu_cb_out;
      idx_q                  <= idx_q + IW'(1);
    end
  end
  // Upper words of add/sub chain the carry; inc/dec become add/sub of zero plus the carry.
  always_comb begin
    run        = state_q == RUN;
    first      = idx_q == '0;
    arith      = mode_q[2:1] == 2'b00;
    incdec     = mode_q[2:1] == 2'b11;
    cmd_ready  = state_q == IDLE;
    rsp_valid  = state_q == DONE;
    rsp_result = result_q;
    rsp_cb_out = carry_q;
    alu_a      = run ? a_q[idx_q*n +: n] : '0;
    alu_b      = (run && !(incdec && !first)) ? b_q[idx_q*n +: n] : '0;
    alu_mode   = !run ? 3'b000 : (incdec && !first) ? {2'b00, mode_q[0]} : mode_q;
    alu_cb_in  = run && (first ? (arith && cbin_q) : ((arith || incdec) && carry_q));
  end
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign rsp_zero = rsp_valid && result_q == '0;
`endif
endmodule
